// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing, completion returned to owner.
// Optional wait-state watchdog enabled by defining APB_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module apb_master_arbiter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic [1:0] req,
    input  logic [1:0] wr,
    input  logic [2:0] addr0,
    input  logic [2:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic [1:0] done,
    output logic [7:0] rdata,
    output logic       err,
    output logic       busy,
    output logic       psel_x,
    output logic       penable,
    output logic       pwrite,
    output logic [2:0] paddr,
    output logic [7:0] pwdata,
    input  logic       pready,
    input  logic       pslverr,
    input  logic [7:0] prdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t     state_reg;
    logic       owner_reg;
    logic       last_owner_reg;
    logic       grant_next;
    logic       timeout_hit;
    logic       in_access;
    logic       xfer_end;
    logic [2:0] req_addr  [2];
    logic [7:0] req_wdata [2];

    assign req_addr[0]  = addr0;
    assign req_addr[1]  = addr1;
    assign req_wdata[0] = wdata0;
    assign req_wdata[1] = wdata1;

    // On a tie the requester that did not own the bus last wins; otherwise the sole requester.
    assign grant_next = (req == 2'b11) ? ~last_owner_reg : req[1];

`ifdef APB_TIMEOUT_EN
    logic [7:0] wait_cnt_reg;
    assign timeout_hit = (wait_cnt_reg == 8'(TIMEOUT_CYCLES)) && !pready;
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    assign in_access = (state_reg == ST_ACCESS);
    assign xfer_end  = in_access && (pready || timeout_hit);
    assign busy      = (state_reg != ST_IDLE);

    // A same-cycle pready takes priority over the watchdog abort.
    assign rdata = (in_access && pready && !pwrite) ? prdata : 8'h00;
    assign err   = in_access && (pready ? pslverr : timeout_hit);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_done
            assign done[gi] = xfer_end && (owner_reg == 1'(gi));
        end
    endgenerate

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            psel_x         <= 1'b0;
            penable        <= 1'b0;
            pwrite         <= 1'b0;
            paddr          <= 3'd0;
            pwdata         <= 8'h00;
`ifdef APB_TIMEOUT_EN
            wait_cnt_reg   <= 8'd0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        pwrite         <= wr[grant_next];
                        paddr          <= req_addr[grant_next];
                        pwdata         <= req_wdata[grant_next];
                        owner_reg      <= grant_next;
                        last_owner_reg <= grant_next;
                        psel_x         <= 1'b1;
                        state_reg      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable   <= 1'b1;
                    state_reg <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                    wait_cnt_reg <= 8'd0;
`endif
                end
                ST_ACCESS: begin
                    if (xfer_end) begin
                        psel_x    <= 1'b0;
                        penable   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
`endif
                end
                default: begin
                    psel_x    <= 1'b0;
                    penable   <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
